// File: rtl/state_flag_seq.sv
// Registered state sequencer: step / jump / dwell-timeout advance with a
// parametrised state-to-flag decode table, all outputs driven from flops.
module state_flag_seq #(
    parameter int                      SW           = 2,
    parameter int                      FW           = 2,
    parameter int                      NUM_STATES   = 4,
    parameter logic [(2**SW)*FW-1:0]   FLAG_TABLE   = 8'h0A,
    parameter logic [2**SW-1:0]        SPEC_MASK    = 4'hB,
    parameter logic [FW-1:0]           DEFAULT_FLAG = '0,
    parameter bit                      HOLD_MODE    = 1'b1,
    parameter int                      TIMEOUT      = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    input  logic          jump_en,
    input  logic [SW-1:0] jump_state,
    output logic [SW-1:0] curr_state,
    output logic [FW-1:0] flag,
    output logic          flag_valid,
    output logic          state_chg,
    output logic          err
);

    localparam int              DW         = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [SW:0]     NUM_ST     = (SW + 1)'(NUM_STATES);
    localparam logic [SW-1:0]   LAST_STATE = SW'(NUM_STATES - 1);
    localparam logic [FW-1:0]   RESET_FLAG = SPEC_MASK[0] ? FLAG_TABLE[FW-1:0] : DEFAULT_FLAG;

    logic [SW-1:0] state_q, state_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [FW-1:0] flag_q, flag_d;
    logic          valid_q, valid_d;
    logic          chg_q, chg_d;
    logic          err_q, err_d;
    logic          step;
    logic          timeout_hit;

    always_comb begin
        state_d     = state_q;
        err_d       = 1'b0;
        step        = 1'b0;
        timeout_hit = (TIMEOUT != 0) && (dwell_q == DWELL_LAST);

        // An unused encoding recovers to state 0 ahead of any request.
        if ({1'b0, state_q} >= NUM_ST) begin
            state_d = '0;
            step    = 1'b1;
        end else if (jump_en && ({1'b0, jump_state} < NUM_ST)) begin
            state_d = jump_state;
            step    = 1'b1;
        end else if (jump_en) begin
            err_d   = 1'b1;
        end else if (advance || timeout_hit) begin
            state_d = (state_q == LAST_STATE) ? '0 : state_q + 1'b1;
            step    = 1'b1;
        end

        if (TIMEOUT == 0 || step)
            dwell_d = '0;
        else if (dwell_q != DWELL_LAST)
            dwell_d = dwell_q + 1'b1;
        else
            dwell_d = dwell_q;

        // Flag follows the next state so it lines up with curr_state.
        if (SPEC_MASK[state_d])
            flag_d = FLAG_TABLE[int'(state_d)*FW +: FW];
        else
            flag_d = HOLD_MODE ? flag_q : DEFAULT_FLAG;

        valid_d = SPEC_MASK[state_d];
        chg_d   = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            dwell_q <= '0;
            flag_q  <= RESET_FLAG;
            valid_q <= SPEC_MASK[0];
            chg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            flag_q  <= flag_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
            err_q   <= err_d;
        end
    end

    assign curr_state = state_q;
    assign flag       = flag_q;
    assign flag_valid = valid_q;
    assign state_chg  = chg_q;
    assign err        = err_q;

endmodule

// File: tb/tb_state_flag_seq.sv
// Four configurations of state_flag_seq driven by shared stimulus and checked
// every cycle against a per-configuration behavioural model.
module tb_state_flag_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       advance = 1'b0;
    logic       jump_en = 1'b0;
    logic [1:0] jump_state = '0;

    logic [1:0] cs [4];
    logic [1:0] fl [4];
    logic       fv [4];
    logic       chg [4];
    logic       er [4];

    always #5 clk = ~clk;

    // 0: defaults  1: HOLD_MODE=0  2: NUM_STATES=3  3: TIMEOUT=5
    state_flag_seq u_def (.clk(clk), .rst(rst), .advance(advance), .jump_en(jump_en),
        .jump_state(jump_state), .curr_state(cs[0]), .flag(fl[0]), .flag_valid(fv[0]),
        .state_chg(chg[0]), .err(er[0]));

    state_flag_seq #(.HOLD_MODE(1'b0)) u_nohold (.clk(clk), .rst(rst), .advance(advance),
        .jump_en(jump_en), .jump_state(jump_state), .curr_state(cs[1]), .flag(fl[1]),
        .flag_valid(fv[1]), .state_chg(chg[1]), .err(er[1]));

    state_flag_seq #(.NUM_STATES(3)) u_n3 (.clk(clk), .rst(rst), .advance(advance),
        .jump_en(jump_en), .jump_state(jump_state), .curr_state(cs[2]), .flag(fl[2]),
        .flag_valid(fv[2]), .state_chg(chg[2]), .err(er[2]));

    state_flag_seq #(.TIMEOUT(5)) u_to5 (.clk(clk), .rst(rst), .advance(advance),
        .jump_en(jump_en), .jump_state(jump_state), .curr_state(cs[3]), .flag(fl[3]),
        .flag_valid(fv[3]), .state_chg(chg[3]), .err(er[3]));

    // Behavioural model: flag table 8'h0A, mask 4'hB, written as plain per-state lists.
    typedef struct {
        int st;
        int dw;
        int fl;
        bit fv;
        bit chg;
        bit er;
    } mdl_t;

    int   TBL   [4] = '{2, 2, 0, 0};
    bit   SPEC  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int   CFG_N [4] = '{4, 4, 3, 4};
    bit   CFG_H [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int   CFG_T [4] = '{0, 0, 0, 5};
    mdl_t m [4];

    int vectors = 0;
    int miscompares = 0;

    function automatic mdl_t model_step(int c, mdl_t cur, bit r, bit a, bit je, int js);
        mdl_t nx;
        bit   moved;
        nx = cur;
        if (r) begin
            nx.st = 0; nx.dw = 0; nx.chg = 0; nx.er = 0;
            nx.fl = SPEC[0] ? TBL[0] : 0;
            nx.fv = SPEC[0];
            return nx;
        end
        moved = 0;
        nx.er = 0;
        if (je && js < CFG_N[c]) begin
            nx.st = js; moved = 1;
        end else if (je) begin
            nx.er = 1;
        end else if (a || (CFG_T[c] != 0 && cur.dw == CFG_T[c] - 1)) begin
            nx.st = (cur.st + 1) % CFG_N[c]; moved = 1;
        end
        if (CFG_T[c] == 0 || moved) nx.dw = 0;
        else if (cur.dw < CFG_T[c] - 1) nx.dw = cur.dw + 1;
        nx.chg = (nx.st != cur.st);
        if (SPEC[nx.st]) nx.fl = TBL[nx.st];
        else if (!CFG_H[c]) nx.fl = 0;
        nx.fv = SPEC[nx.st];
        return nx;
    endfunction

    always @(posedge clk)
        for (int i = 0; i < 4; i++)
            m[i] = model_step(i, m[i], rst, advance, jump_en, int'(jump_state));

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d.curr_state", i), 32'(cs[i]),  m[i].st);
            chk($sformatf("u%0d.flag", i),       32'(fl[i]),  m[i].fl);
            chk($sformatf("u%0d.flag_valid", i), 32'(fv[i]),  32'(m[i].fv));
            chk($sformatf("u%0d.state_chg", i),  32'(chg[i]), 32'(m[i].chg));
            chk($sformatf("u%0d.err", i),        32'(er[i]),  32'(m[i].er));
        end
    endtask

    task automatic cyc(bit r, bit a, bit je, int js);
        rst = r; advance = a; jump_en = je; jump_state = 2'(js);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    int exp_st [4] = '{1, 2, 3, 0};
    int exp_fl [4] = '{2, 2, 0, 2};
    bit exp_fv [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        @(negedge clk);

        // Reset defaults
        cyc(1, 0, 0, 0);
        chk("T1.state", 32'(cs[0]), 0);
        chk("T1.flag", 32'(fl[0]), 2);
        chk("T1.valid", 32'(fv[0]), 1);
        chk("T1.chg", 32'(chg[0]), 0);
        chk("T1.err", 32'(er[0]), 0);

        // Four advances, wrap, held flag on unspecified state
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, 0);
            chk($sformatf("T2.state%0d", k), 32'(cs[0]), exp_st[k]);
            chk($sformatf("T2.flag%0d", k), 32'(fl[0]), exp_fl[k]);
            chk($sformatf("T2.valid%0d", k), 32'(fv[0]), 32'(exp_fv[k]));
            chk($sformatf("T2.chg%0d", k), 32'(chg[0]), 1);
            if (k == 1) begin
                chk("T3.flag", 32'(fl[1]), 0);
                chk("T3.valid", 32'(fv[1]), 0);
            end
        end

        // Jump beats advance; illegal jump on NUM_STATES=3 holds and flags err
        cyc(0, 1, 1, 3);
        chk("T4.state", 32'(cs[0]), 3);
        chk("T4.flag", 32'(fl[0]), 0);
        chk("T4.n3_state", 32'(cs[2]), 1);
        chk("T4.n3_err", 32'(er[2]), 1);
        cyc(0, 0, 0, 0);
        chk("T4.n3_err_pulse", 32'(er[2]), 0);

        // Dwell timeout auto-advance
        cyc(1, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            cyc(0, 0, 0, 0);
            chk($sformatf("T5.state_e%0d", k), 32'(cs[3]), k / 5);
        end
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int k = 4; k <= 8; k++) cyc(0, 0, 0, 0);
        chk("T5.adv_dwell", 32'(cs[3]), 2);

        // Reset mid-dwell with advance asserted
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 0, 0);
        chk("T6.state", 32'(cs[3]), 0);
        chk("T6.flag", 32'(fl[3]), 2);
        chk("T6.chg", 32'(chg[3]), 0);
        for (int k = 1; k <= 5; k++) cyc(0, 0, 0, 0);
        chk("T6.dwell_cleared", 32'(cs[3]), 1);

        // Randomised traffic
        for (int k = 0; k < 2000; k++)
            cyc($urandom_range(63) == 0, $urandom_range(2) == 0,
                $urandom_range(4) == 0, int'($urandom_range(3)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
